// File: rtl/otter_io_pkg.sv
// Shared register map for OTTER IOBUS peripherals: word offsets and CTRL field
// positions, so firmware headers and other responders use the same constants.
package otter_io_pkg;

  typedef enum logic [1:0] {
    CTRL_OFS   = 2'd0,
    LOAD_OFS   = 2'd1,
    COUNT_OFS  = 2'd2,
    STATUS_OFS = 2'd3
  } reg_ofs_e;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_AUTO_BIT  = 1;
  localparam int unsigned CTRL_IRQEN_BIT = 2;
  localparam int unsigned PRESC_LSB      = 8;
  localparam int unsigned PRESC_MSB      = 15;

  localparam int unsigned STATUS_EXPIRED_BIT = 0;

endpackage

// File: rtl/otter_timer_io_if.sv
// OTTER IOBUS responder-side bundle: address, write data, write strobe, read data.
interface otter_timer_io_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
  modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/timer_prescaler.sv
// Divides the enabled clock by (presc+1), emitting a one-cycle tick on the
// last count of each period.
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] pcnt;

  assign tick = en && (pcnt == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (!en || clear) begin
      pcnt <= '0;
    end else if (pcnt == presc) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/otter_timer_io.sv
// Memory-mapped down-counting timer on the OTTER IOBUS with sticky expiry
// flag, optional auto-reload and a level interrupt.
module otter_timer_io
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0040
) (
  input  logic             clk,
  input  logic             RST,
  otter_timer_io_if.slave  bus,
  output logic             INTR
);

  logic        en, auto_reload, irq_en, expired;
  logic [7:0]  presc;
  logic [31:0] load_val, count;

  logic        hit, tick, expire_now;
  logic        ctrl_we, load_we, status_we;
  reg_ofs_e    sel;
  logic        addr_unused;

  assign hit         = (bus.IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign sel         = reg_ofs_e'(bus.IOBUS_ADDR[3:2]);
  assign addr_unused = ^bus.IOBUS_ADDR[1:0];

  assign ctrl_we   = hit && bus.IOBUS_WR && (sel == CTRL_OFS);
  assign load_we   = hit && bus.IOBUS_WR && (sel == LOAD_OFS);
  assign status_we = hit && bus.IOBUS_WR && (sel == STATUS_OFS);

  timer_prescaler u_prescaler (
    .clk   (clk),
    .rst   (RST),
    .en    (en),
    .clear (ctrl_we),
    .presc (presc),
    .tick  (tick)
  );

  assign expire_now = tick && (count == '0);

  // Assignment order encodes the collision priorities: software writes to
  // CTRL/LOAD override the tick's effect, while expiry overrides a STATUS clear.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      presc       <= '0;
      load_val    <= '0;
      count       <= '0;
      expired     <= 1'b0;
    end else begin
      if (status_we && bus.IOBUS_OUT[STATUS_EXPIRED_BIT]) begin
        expired <= 1'b0;
      end
      if (tick) begin
        if (count != '0) begin
          count <= count - 32'd1;
        end else begin
          expired <= 1'b1;
          if (auto_reload) begin
            count <= load_val;
          end else begin
            en <= 1'b0;
          end
        end
      end
      if (ctrl_we) begin
        en          <= bus.IOBUS_OUT[CTRL_EN_BIT];
        auto_reload <= bus.IOBUS_OUT[CTRL_AUTO_BIT];
        irq_en      <= bus.IOBUS_OUT[CTRL_IRQEN_BIT];
        presc       <= bus.IOBUS_OUT[PRESC_MSB:PRESC_LSB];
      end
      if (load_we) begin
        load_val <= bus.IOBUS_OUT;
        count    <= bus.IOBUS_OUT;
      end
    end
  end

  always_comb begin
    bus.IOBUS_IN = '0;
    if (hit) begin
      unique case (sel)
        CTRL_OFS:   bus.IOBUS_IN = {16'h0000, presc, 5'b00000, irq_en, auto_reload, en};
        LOAD_OFS:   bus.IOBUS_IN = load_val;
        COUNT_OFS:  bus.IOBUS_IN = count;
        STATUS_OFS: bus.IOBUS_IN = {31'h0, expired};
        default:    bus.IOBUS_IN = '0;
      endcase
    end
  end

  assign INTR = expired && irq_en;

endmodule

// File: tb/tb_otter_timer_io.sv
// Scoreboard bench for otter_timer_io: stimulus pushes model-predicted read
// data and INTR per cycle; a negedge monitor pops and compares.
module tb_otter_timer_io;

  localparam logic [31:0] BASE = 32'h1100_0040;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic intr;

  otter_timer_io_if bus ();

  otter_timer_io #(.BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .RST  (rst),
    .bus  (bus.slave),
    .INTR (intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_en, m_auto, m_irq, m_exp;
  logic [7:0]  m_presc;
  logic [31:0] m_load, m_count;
  int unsigned m_phase;

  task automatic m_reset();
    m_en = 0; m_auto = 0; m_irq = 0; m_exp = 0;
    m_presc = '0; m_load = '0; m_count = '0; m_phase = 0;
  endtask

  function automatic bit m_hit(logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic bit m_tick();
    return m_en && ((m_phase % (32'(m_presc) + 1)) == 32'(m_presc));
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    if (!m_hit(a)) return 32'h0;
    case (a[3:2])
      2'd0:    return {16'h0, m_presc, 5'b0, m_irq, m_auto, m_en};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {31'h0, m_exp};
    endcase
  endfunction

  task automatic m_step(bit wr, logic [31:0] a, logic [31:0] d);
    bit t, expiring, ctrl_w;
    bit n_en, n_exp;
    logic [31:0] n_count;
    t = m_tick();
    expiring = t && (m_count == 0);
    ctrl_w = wr && m_hit(a) && (a[3:2] == 2'd0);
    n_en = m_en; n_exp = m_exp; n_count = m_count;
    if (t) begin
      if (m_count != 0) n_count = m_count - 1;
      else begin
        n_exp = 1;
        if (m_auto) n_count = m_load; else n_en = 0;
      end
    end
    if (wr && m_hit(a)) begin
      case (a[3:2])
        2'd0: begin
          n_en = d[0]; m_auto = d[1]; m_irq = d[2]; m_presc = d[15:8];
        end
        2'd1: begin m_load = d; n_count = d; end
        2'd3: if (d[0] && !expiring) n_exp = 0;
        default: ;
      endcase
    end
    if (!m_en || ctrl_w) m_phase = 0; else m_phase = m_phase + 1;
    m_en = n_en; m_exp = n_exp; m_count = n_count;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One bus cycle, entered and left at posedge+1.
  task automatic cyc(bit wr, logic [31:0] a, logic [31:0] d);
    bus.IOBUS_WR = wr; bus.IOBUS_ADDR = a; bus.IOBUS_OUT = d;
    sb.push_back('{addr: a, rd: m_read(a), irq: m_exp & m_irq});
    @(posedge clk);
    if (!rst) m_step(wr, a, d);
    #1;
  endtask

  task automatic wr_reg(logic [31:0] ofs, logic [31:0] d);
    cyc(1'b1, BASE + ofs, d);
  endtask

  task automatic rd_reg(logic [31:0] ofs);
    cyc(1'b0, BASE + ofs, 32'h0);
  endtask

  task automatic wait_expired(string name, int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      rd_reg(32'hC);
      ok = m_exp;
    end
    if (!ok) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("iobus_in", bus.IOBUS_IN, e.rd);
      chk("intr", {31'h0, intr}, {31'h0, e.irq});
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    bit done;
    int r;
    logic [31:0] a, d;

    bus.IOBUS_WR = 0; bus.IOBUS_ADDR = '0; bus.IOBUS_OUT = '0;
    m_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rd_reg(32'(i * 4));
    rst = 0;

    // One-shot, PRESC=0
    wr_reg(32'h4, 32'd3);
    wr_reg(32'h0, 32'h5);
    repeat (6) rd_reg(32'h8);
    rd_reg(32'h0);
    rd_reg(32'hC);

    // Auto-reload with prescale, then STATUS clear colliding with expiry
    wr_reg(32'hC, 32'h1);
    wr_reg(32'h4, 32'd1);
    wr_reg(32'h0, 32'h207);
    repeat (8) rd_reg(32'hC);
    wr_reg(32'hC, 32'h1);
    repeat (14) rd_reg(32'h8);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_tick() && m_count == 0) begin
        wr_reg(32'hC, 32'h1);
        done = 1;
      end else rd_reg(32'h8);
    end
    if (!done) chk("clr_collide_timeout", 32'h0, 32'h1);
    rd_reg(32'hC);

    // LOAD write on a tick cycle
    wr_reg(32'h4, 32'd50);
    wr_reg(32'h0, 32'h203);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_tick() && m_count != 0) begin
        wr_reg(32'h4, 32'd10);
        done = 1;
      end else rd_reg(32'h8);
    end
    if (!done) chk("load_collide_timeout", 32'h0, 32'h1);
    rd_reg(32'h8);

    // LOAD=0 with auto-reload expires every tick
    wr_reg(32'h4, 32'd0);
    wr_reg(32'h0, 32'h7);
    repeat (3) begin wr_reg(32'hC, 32'h1); rd_reg(32'hC); end

    // Decode
    cyc(1'b0, 32'h1100_0050, 32'h0);
    cyc(1'b0, 32'h1100_003C, 32'h0);
    wr_reg(32'h0, 32'h0);
    wr_reg(32'h8, 32'hFFFF);
    rd_reg(32'h8);
    wr_reg(32'h0, 32'hFFFF_FFFF);
    rd_reg(32'h0);
    cyc(1'b0, BASE + 32'h3, 32'h0);

    // IRQ masking
    wr_reg(32'h0, 32'h0);
    wr_reg(32'hC, 32'h1);
    wr_reg(32'h4, 32'd2);
    wr_reg(32'h0, 32'h1);
    wait_expired("mask", 20);
    rd_reg(32'hC);
    wr_reg(32'h0, 32'h4);
    rd_reg(32'hC);
    rd_reg(32'hC);

    // Asynchronous reset with COUNT=5, EXPIRED=1, counting
    wr_reg(32'hC, 32'h1);
    wr_reg(32'h4, 32'd0);
    wr_reg(32'h0, 32'h5);
    wait_expired("prep", 20);
    wr_reg(32'h4, 32'd5);
    wr_reg(32'h0, 32'hFF07);
    rd_reg(32'h8);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      bus.IOBUS_WR = 0; bus.IOBUS_ADDR = BASE + 32'(i * 4);
      #1;
      chk("rst_rd", bus.IOBUS_IN, 32'h0);
      chk("rst_intr", {31'h0, intr}, 32'h0);
    end
    m_reset();
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 4; i++) rd_reg(32'(i * 4));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        6: wr_reg(32'h0, {16'h0, 8'($urandom_range(0, 3)), 5'b0, 3'($urandom_range(0, 7))});
        7: wr_reg(32'h4, 32'($urandom_range(0, 6)));
        8: wr_reg(32'hC, 32'($urandom_range(0, 1)));
        9: begin
          a = (r[0] ^ $urandom_range(0, 1) ? BASE + 32'h10 : BASE - 32'h10) + 32'($urandom_range(0, 3) * 4);
          d = $urandom;
          cyc(1'($urandom_range(0, 1)), a, d);
        end
        default: rd_reg(32'($urandom_range(0, 3) * 4));
      endcase
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
